// File: rtl/dmem_line_responder.sv
// Main-memory line responder for the dCache miss path: fixed-latency line fills and writebacks
// over a word-addressed backing store. Optional build macro: CRITICAL_WORD_FIRST_EN.
module dmem_line_responder #(
  parameter int LINE_WORDS  = 2,
  parameter int DEPTH_WORDS = 4096,
  parameter int LATENCY     = 20
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     req_valid,
  output logic                     req_ready,
  input  logic                     req_write,
  input  logic [31:0]              req_addr,
  input  logic [32*LINE_WORDS-1:0] req_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_last,
  output logic                     rsp_wack
);

  localparam int OW = $clog2(LINE_WORDS);
  localparam int AW = $clog2(DEPTH_WORDS);
  localparam int IW = AW - OW;
  localparam int CW = $clog2(LATENCY + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                  state;
  state_t                  state_nxt;
  logic [CW-1:0]           cnt;
  logic [OW-1:0]           beat;
  logic [IW-1:0]           line_q;
  logic                    wr_q;
  logic [32*LINE_WORDS-1:0] wdata_q;
  logic [OW-1:0]           rd_off;
  logic [AW-1:0]           rd_addr;
  logic                    accept;
  logic                    beat_done;
  logic                    commit;
  logic                    addr_unused;

  logic [31:0] mem [DEPTH_WORDS];

  assign accept    = req_valid && req_ready;
  assign beat_done = rsp_valid && rsp_ready;
  // Writeback lands on the edge that leaves WAIT, so a reset during WAIT never touches memory.
  assign commit    = (state == S_WAIT) && (cnt == '0) && wr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_last  = 1'b0;
    rsp_wack  = 1'b0;
    rsp_rdata = '0;
    unique case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = S_WAIT;
      end
      S_WAIT: begin
        if (cnt == '0) state_nxt = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        rsp_wack  = wr_q;
        rsp_last  = wr_q || (beat == OW'(LINE_WORDS - 1));
        rsp_rdata = wr_q ? '0 : mem[rd_addr];
        if (rsp_ready && rsp_last) state_nxt = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      cnt     <= '0;
      beat    <= '0;
      line_q  <= '0;
      wr_q    <= 1'b0;
      wdata_q <= '0;
    end else begin
      if (accept) begin
        cnt     <= CW'(LATENCY - 1);
        beat    <= '0;
        line_q  <= req_addr[AW+1:OW+2];
        wr_q    <= req_write;
        wdata_q <= req_wdata;
      end else if ((state == S_WAIT) && (cnt != '0)) begin
        cnt <= cnt - 1'b1;
      end
      if (beat_done) beat <= beat + 1'b1;
    end
  end

`ifdef CRITICAL_WORD_FIRST_EN
  logic [OW-1:0] w0_q;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      w0_q <= '0;
    end else if (accept) begin
      w0_q <= req_addr[OW+1:2];
    end
  end

  // Offset arithmetic wraps naturally inside the line.
  assign rd_off      = w0_q + beat;
  assign addr_unused = ^{req_addr[31:AW+2], req_addr[1:0]};
`else
  assign rd_off      = beat;
  assign addr_unused = ^{req_addr[31:AW+2], req_addr[1:0], req_addr[OW+1:2]};
`endif

  assign rd_addr = {line_q, rd_off};

  // NOTE: the backing store is deliberately not reset; it must survive RESET_N like real DRAM.
  always_ff @(posedge CLK) begin
    if (commit) begin
      for (int k = 0; k < LINE_WORDS; k++) begin
        mem[{line_q, OW'(k)}] <= wdata_q[32*k +: 32];
      end
    end
  end

endmodule
